exu_muldiv: RTL and testbench

- Parametrised multi-cycle execute unit for the RV M extension, running alongside the single-cycle ALU in the execute stage.
- Accepts one operation per valid/ready handshake. Runs an iterative shift-add multiply or restoring divide, then holds the result until the downstream stage accepts it.
- Adds what the single-cycle execute stage lacks: back-pressure, multi-cycle latency, flush mid-operation, and width/word-mode parametrisation.

---
 rtl/exu_muldiv.sv | 202 ++++++++++++++++++++
 tb/tb_exu_muldiv.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_muldiv.sv
//-----------------------------------------------------------------------------
// exu_muldiv
// Iterative multiply/divide unit for the RISC-V M extension. It accepts one
// operation per in_valid/in_ready handshake and runs a shift-add multiply or a
// restoring divide on operand magnitudes, one bit per cycle. It then holds the
// result until out_ready. Divide-by-zero and signed overflow skip the
// iteration and complete on the cycle after accept.
//
// Ports:
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   flush                drops any in-flight or held operation
//   in_valid/in_ready    request handshake; in_ready is high only when idle
//   in_op, in_word       funct3 encoding and *W variant select
//   in_src1, in_src2     operands (sampled at accept only)
//   in_rd, in_tag        carried unchanged to out_rd/out_tag
//   out_valid/out_ready  result handshake
//   out_result           XLEN-bit result
//   busy                 unit is not idle
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module exu_muldiv #(
  parameter int XLEN     = 64,
  parameter int WORD_OPS = 1,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [4:0]       in_rd,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [4:0]       out_rd,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(31);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_reg, state_next;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // ---------------- operand decode at accept ----------------
  logic            is_div, word_op, src1_signed, src2_signed;
  logic            a_neg, b_neg, div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, a_min, fast_raw, fast_res, div_init;

  assign is_div      = in_op[2];
  // MULHW/MULHSUW/MULHUW do not exist; those encodings fall back to full width.
  assign word_op     = (WORD_OPS != 0) && in_word && ((in_op == 3'd0) || is_div);
  assign src1_signed = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
  assign src2_signed = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);

  always_comb begin
    a_ext = in_src1;
    b_ext = in_src2;
    if (word_op) begin
      // MULW, DIVW, REMW sign-extend (funct3 bit 0 clear); DIVUW/REMUW zero-extend.
      a_ext = in_op[0] ? XLEN'(in_src1[31:0]) : sext32(in_src1[31:0]);
      b_ext = in_op[0] ? XLEN'(in_src2[31:0]) : sext32(in_src2[31:0]);
    end
  end

  assign a_neg = src1_signed && a_ext[XLEN-1];
  assign b_neg = src2_signed && b_ext[XLEN-1];
  assign a_mag = a_neg ? -a_ext : a_ext;   // most-negative maps to 2^(XLEN-1) unsigned
  assign b_mag = b_neg ? -b_ext : b_ext;
  // Word dividends are pre-shifted so the divider consumes their 32 bits MSB-first.
  assign div_init = word_op ? (a_mag << (XLEN - 32)) : a_mag;

  assign a_min    = word_op ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero = is_div && (b_ext == '0);
  assign div_ovf  = is_div && !in_op[0] && (a_ext == a_min) && (b_ext == '1);
  assign fast     = div_zero || div_ovf;

  always_comb begin
    if (div_zero) fast_raw = in_op[1] ? a_ext : '1;      // REM: dividend, DIV: all ones
    else          fast_raw = in_op[1] ? '0 : a_ext;      // overflow: REM 0, DIV dividend
  end
  assign fast_res = word_op ? sext32(fast_raw[31:0]) : fast_raw;

  // ---------------- iteration datapath ----------------
  // x_reg: multiplier (shifts right) or dividend/quotient (shifts left)
  // y_reg: multiplicand (shifts left) or divisor in the low half
  // acc_reg: product or partial remainder in the low half
  logic [2:0]        op_reg;
  logic              word_reg, neg_q_reg, neg_r_reg;
  logic [CW-1:0]     cnt_reg;
  logic [XLEN-1:0]   x_reg, x_step, result_reg, div_q, div_r, raw_res, final_res;
  logic [2*XLEN-1:0] y_reg, y_step, acc_reg, acc_step, mul_prod;
  logic [XLEN:0]     div_shift, div_diff;
  logic [4:0]        rd_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic              last;

  assign div_shift = {acc_reg[XLEN-1:0], x_reg[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, y_reg[XLEN-1:0]};
  assign last      = (cnt_reg == (word_reg ? LAST_WORD : LAST_FULL));

  always_comb begin
    x_step   = x_reg;
    y_step   = y_reg;
    acc_step = acc_reg;
    if (op_reg[2]) begin
      // Restoring step: keep the trial difference only if it did not go negative.
      x_step   = {x_reg[XLEN-2:0], ~div_diff[XLEN]};
      acc_step = {{XLEN{1'b0}}, (div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0])};
    end else begin
      acc_step = acc_reg + (x_reg[0] ? y_reg : '0);
      x_step   = x_reg >> 1;
      y_step   = y_reg << 1;
    end
  end

  // Sign fix-up applied to the values produced by the final iteration.
  always_comb begin
    mul_prod = neg_q_reg ? -acc_step : acc_step;
    div_q    = neg_q_reg ? -x_step : x_step;
    div_r    = neg_r_reg ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    if (op_reg[2])              raw_res = op_reg[1] ? div_r : div_q;
    else if (op_reg[1:0] == 2'd0) raw_res = mul_prod[XLEN-1:0];
    else                        raw_res = mul_prod[2*XLEN-1:XLEN];
    final_res = word_reg ? sext32(raw_res[31:0]) : raw_res;
  end

  // ---------------- control FSM ----------------
  assign accept = in_valid && (state_reg == IDLE) && !flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (in_valid) state_next = fast ? DONE : CALC;
        CALC:    if (last) state_next = DONE;
        DONE:    if (out_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      op_reg     <= '0;
      word_reg   <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      cnt_reg    <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      rd_reg     <= '0;
      tag_reg    <= '0;
    end else if (accept) begin
      op_reg    <= in_op;
      word_reg  <= word_op;
      neg_q_reg <= a_neg ^ b_neg;
      neg_r_reg <= a_neg;
      cnt_reg   <= '0;
      x_reg     <= is_div ? div_init : b_mag;
      y_reg     <= {{XLEN{1'b0}}, (is_div ? b_mag : a_mag)};
      acc_reg   <= '0;
      rd_reg    <= in_rd;
      tag_reg   <= in_tag;
      if (fast) result_reg <= fast_res;
    end else if ((state_reg == CALC) && !flush) begin
      x_reg   <= x_step;
      y_reg   <= y_step;
      acc_reg <= acc_step;
      cnt_reg <= cnt_reg + CW'(1);
      if (last) result_reg <= final_res;
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign out_result = result_reg;
  assign out_rd     = rd_reg;
  assign out_tag    = tag_reg;

endmodule

// File: tb/tb_exu_muldiv.sv
//-----------------------------------------------------------------------------
// tb_exu_muldiv
// Directed test of exu_muldiv (XLEN=64, WORD_OPS=1, TAG_W=8) with
// hand-computed expected results and latencies. Latency is counted in clock
// edges from the edge after which the request is presented.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_exu_muldiv;

  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_word, out_ready;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2;
  logic [4:0]  in_rd;
  logic [7:0]  in_tag;
  logic        in_ready, out_valid, busy;
  logic [63:0] out_result;
  logic [4:0]  out_rd;
  logic [7:0]  out_tag;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic        word;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  exu_muldiv #(.XLEN(64), .WORD_OPS(1), .TAG_W(8)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, passed=%0d checks=%0d", passed, checks);
    $fatal(1);
  end

  // Present a request for one cycle; returns #1 after the accepting edge with
  // the operand inputs scrambled, since they must have been captured already.
  task automatic start_op(input logic [2:0] op, input logic word, input logic [63:0] s1,
                          input logic [63:0] s2, input logic [4:0] rd, input logic [7:0] tag);
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = op; in_word = word;
    in_src1 = s1; in_src2 = s2; in_rd = rd; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_src1 = {$urandom, $urandom}; in_src2 = {$urandom, $urandom};
    in_rd = 5'($urandom); in_tag = 8'($urandom); in_op = 3'($urandom);
  endtask

  // Counts edges until out_valid (lat=1 means right after the accepting edge);
  // lat=-1 when the bound expires.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  // Full transaction: issue, wait, sample, one-cycle out_ready handshake.
  task automatic do_op(input vec_t v, input logic [4:0] rd, input logic [7:0] tag,
                       output logic [63:0] res, output logic [4:0] rd_o,
                       output logic [7:0] tag_o, output int lat);
    start_op(v.op, v.word, v.s1, v.s2, rd, tag);
    wait_valid(lat);
    res = out_result; rd_o = out_rd; tag_o = out_tag;
    $display("op=%0d word=%0b src1=%h src2=%h -> result=%h rd=%0d tag=%h latency=%0d",
             v.op, v.word, v.s1, v.s2, res, rd_o, tag_o, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_table(input vec_t v[], input string name);
    logic [63:0] res;
    logic [4:0]  rd_o;
    logic [7:0]  tag_o;
    int          lat;
    for (int i = 0; i < v.size(); i++) begin
      do_op(v[i], 5'(i + 3), 8'(8'hC0 + i), res, rd_o, tag_o, lat);
      checks++;
      if (res !== v[i].exp || lat != v[i].lat || rd_o !== 5'(i + 3) || tag_o !== 8'(8'hC0 + i))
        $display("FAIL %s[%0d]: result=%h latency=%0d rd=%0d tag=%h, required result=%h latency=%0d rd=%0d tag=%h",
                 name, i, res, lat, rd_o, tag_o, v[i].exp, v[i].lat, i + 3, 8'hC0 + i);
      else passed++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_src1 = '0; in_src2 = '0; in_rd = '0; in_tag = '0;
    #22;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0 || out_rd !== 5'd0 || out_tag !== 8'd0)
      $display("FAIL reset_state: valid=%b busy=%b result=%h rd=%0d tag=%h, required all zero",
               out_valid, busy, out_result, out_rd, out_tag);
    else passed++;
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%b, required 1", in_ready);
    else passed++;
  endtask

  task automatic test_mul();
    vec_t v[] = new[5];
    v[0] = '{3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65};  // MUL
    v[1] = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65};                    // MULHU
    v[2] = '{3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};  // MULH -1*-1
    v[3] = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 65};                                              // MULHSU -1*(2^64-1)
    v[4] = '{3'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};  // MULH with in_word
    run_table(v, "mul");
  endtask

  task automatic test_div();
    vec_t v[] = new[7];
    v[0] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};  // DIV -7/2
    v[1] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65};  // REM -7%2
    v[2] = '{3'd5, 1'b0, 64'd7, 64'd2, 64'd3, 65};                                      // DIVU
    v[3] = '{3'd7, 1'b0, 64'd7, 64'd2, 64'd1, 65};                                      // REMU
    v[4] = '{3'd4, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65};  // DIV 7/-2
    v[5] = '{3'd6, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65};                    // REM 7%-2
    v[6] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'd1, 64'h8000_0000_0000_0000, 65};  // min/1
    run_table(v, "div");
  endtask

  task automatic test_special();
    vec_t v[] = new[6];
    v[0] = '{3'd5, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};                   // DIVU /0
    v[1] = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};                                       // REM /0
    v[2] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000, 1};                                               // DIV overflow
    v[3] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};   // REM overflow
    v[4] = '{3'd4, 1'b0, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};                    // DIV /0
    v[5] = '{3'd5, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65};  // DIVU: no overflow
    run_table(v, "special");
  endtask

  task automatic test_word();
    vec_t v[] = new[6];
    v[0] = '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33};  // MULW
    v[1] = '{3'd5, 1'b1, 64'hFFFF_FFFF_0000_0010, 64'd4, 64'd4, 33};                    // DIVUW
    v[2] = '{3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};  // REMW -7%2
    v[3] = '{3'd7, 1'b1, 64'h1234_5678_8000_0001, 64'hFFFF_FFFF_0000_0000,
             64'hFFFF_FFFF_8000_0001, 1};                                               // REMUW /0
    v[4] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000, 1};                                               // DIVW overflow
    v[5] = '{3'd4, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1};   // DIVW /0 (low word)
    run_table(v, "word");
  endtask

  task automatic test_backpressure();
    int          lat;
    logic        stable = 1'b1;
    logic [63:0] res;
    start_op(3'd0, 1'b0, 64'h1234, 64'h10, 5'd7, 8'hA7);
    wait_valid(lat);
    res = out_result;
    $display("op=0 word=0 src1=%h src2=%h -> result=%h rd=%0d tag=%h latency=%0d (held)",
             64'h1234, 64'h10, res, out_rd, out_tag, lat);
    checks++;
    if (res !== 64'h12340 || lat != 65 || out_rd !== 5'd7 || out_tag !== 8'hA7)
      $display("FAIL bp_result: result=%h latency=%0d rd=%0d tag=%h, required 0000000000012340 65 7 a7",
               res, lat, out_rd, out_tag);
    else passed++;
    // A competing request is presented throughout the hold and the handshake.
    in_valid = 1'b1; in_op = 3'd5; in_word = 1'b0; in_src1 = 64'd9; in_src2 = 64'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== 64'h12340 || out_rd !== 5'd7 ||
          out_tag !== 8'hA7 || in_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) $display("FAIL bp_hold: outputs changed or in_ready rose while held, stable=%b, required 1", stable);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL bp_release: valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    else passed++;
  endtask

  task automatic test_back_to_back();
    vec_t v[] = new[2];
    v[0] = '{3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65};                                    // REMU
    v[1] = '{3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 64'd2, 65};                    // MULHU 2^63*4
    run_table(v, "b2b");
  endtask

  task automatic test_flush();
    vec_t        v;
    logic [63:0] res;
    logic [4:0]  rd_o;
    logic [7:0]  tag_o;
    int          lat;
    logic        seen = 1'b0;
    // flush together with in_valid while idle: nothing accepted
    @(posedge clk); #1;
    in_valid = 1'b1; flush = 1'b1; in_op = 3'd0; in_word = 1'b0; in_src1 = 64'd3; in_src2 = 64'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_idle: busy=%b in_ready=%b, required 0 1", busy, in_ready);
    else passed++;
    // flush at CALC cycle 20
    start_op(3'd4, 1'b0, 64'd1000, 64'd3, 5'd11, 8'h11);
    repeat (19) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL flush_calc: valid=%b in_ready=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
    else passed++;
    v = '{3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65};
    do_op(v, 5'd12, 8'h12, res, rd_o, tag_o, lat);
    checks++;
    if (res !== 64'd14 || lat != 65 || rd_o !== 5'd12 || tag_o !== 8'h12)
      $display("FAIL flush_next_op: result=%h latency=%0d rd=%0d tag=%h, required 14 65 12 12",
               res, lat, rd_o, tag_o);
    else passed++;
    // flush and out_ready together in DONE: flush wins, no output afterwards
    start_op(3'd5, 1'b0, 64'd9, 64'd0, 5'd13, 8'h13);
    checks++;
    if (out_valid !== 1'b1) $display("FAIL flush_done_setup: valid=%b, required 1", out_valid);
    else passed++;
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    repeat (5) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_done: valid seen=%b in_ready=%b, required 0 1", seen, in_ready);
    else passed++;
  endtask

  task automatic test_async_reset();
    vec_t        v;
    logic [63:0] res;
    logic [4:0]  rd_o;
    logic [7:0]  tag_o;
    int          lat;
    start_op(3'd0, 1'b0, 64'd3, 64'd5, 5'd9, 8'h5A);
    repeat (10) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 64'd0 || out_rd !== 5'd0 || out_tag !== 8'd0)
      $display("FAIL async_reset: valid=%b busy=%b result=%h rd=%0d tag=%h, required all zero",
               out_valid, busy, out_result, out_rd, out_tag);
    else passed++;
    @(negedge clk); rstn = 1'b1;
    v = '{3'd0, 1'b0, 64'd6, 64'd7, 64'd42, 65};
    do_op(v, 5'd20, 8'h20, res, rd_o, tag_o, lat);
    checks++;
    if (res !== 64'd42 || lat != 65 || rd_o !== 5'd20 || tag_o !== 8'h20)
      $display("FAIL after_reset_op: result=%h latency=%0d rd=%0d tag=%h, required 42 65 20 20",
               res, lat, rd_o, tag_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_word();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
